sprite_draw_scheduler: RTL and testbench



---
 rtl/sprite_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/sprite_draw_scheduler.sv | 165 ++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite draw scheduler and its arbiter.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;
  localparam int COLOUR_W         = 3;
  localparam int X_W              = 8;
  localparam int Y_W              = 7;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx
);

  always_comb begin : search
    int   j;
    logic found;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        winner[j]  = 1'b1;
        win_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin sharing of the VGA plot port; sweeps one sprite block per grant.
// Optional erase of the previous position: define SPRITE_DRAW_SCHEDULER_ERASE_EN.
//
// state | meaning
// IDLE  | waiting for any req; arbitrate and latch winner
// ERASE | sweep previous block of the winner with BG_COLOUR
// DRAW  | sweep block at latched x/y with latched colour
// DONE  | pulse done to winner, advance rr_ptr
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int                  NUM_REQ   = 4,
  parameter int                  SPRITE_W  = 4,
  parameter int                  SPRITE_H  = 4,
  parameter int                  SCREEN_W  = SCREEN_W_DEFAULT,
  parameter int                  SCREEN_H  = SCREEN_H_DEFAULT,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*X_W-1:0]        x_in,
  input  logic [NUM_REQ*Y_W-1:0]        y_in,
  input  logic [NUM_REQ*COLOUR_W-1:0]   colour_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [X_W-1:0]                vga_x,
  output logic [Y_W-1:0]                vga_y,
  output logic [COLOUR_W-1:0]           vga_colour,
  output logic                          vga_plot,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int XE_W  = X_W + 1;
  localparam int YE_W  = Y_W + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ERASE = ERASE;
  localparam logic [1:0] ST_DRAW  = DRAW;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [CX_W-1:0]  CX_LAST  = CX_W'(SPRITE_W - 1);
  localparam logic [CY_W-1:0]  CY_LAST  = CY_W'(SPRITE_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [XE_W-1:0]  CLIP_X   = XE_W'(SCREEN_W);
  localparam logic [YE_W-1:0]  CLIP_Y   = YE_W'(SCREEN_H);

  logic [1:0]          state;
  logic [1:0]          idle_next;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  gnt_lat;
  logic [NUM_REQ-1:0]  arb_winner;
  logic [IDX_W-1:0]    arb_idx;
  logic [X_W-1:0]      x_lat;
  logic [Y_W-1:0]      y_lat;
  logic [COLOUR_W-1:0] col_lat;
  logic [CX_W-1:0]     cx;
  logic [CY_W-1:0]     cy;
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [XE_W-1:0]     px;
  logic [YE_W-1:0]     py;
  logic                sweeping;
  logic                last_px;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (arb_winner),
    .win_idx (arb_idx)
  );

`ifdef SPRITE_DRAW_SCHEDULER_ERASE_EN
  logic [X_W-1:0]     last_x [NUM_REQ];
  logic [Y_W-1:0]     last_y [NUM_REQ];
  logic [NUM_REQ-1:0] last_valid;

  assign idle_next = last_valid[arb_idx] ? ST_ERASE : ST_DRAW;
  assign base_x    = (state == ST_ERASE) ? last_x[win_idx] : x_lat;
  assign base_y    = (state == ST_ERASE) ? last_y[win_idx] : y_lat;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        last_x[i] <= '0;
        last_y[i] <= '0;
      end
    end else if (state == ST_DONE) begin
      last_x[win_idx]     <= x_lat;
      last_y[win_idx]     <= y_lat;
      last_valid[win_idx] <= 1'b1;
    end
  end
`else
  assign idle_next = ST_DRAW;
  assign base_x    = x_lat;
  assign base_y    = y_lat;
`endif

  // Extra top bit keeps off-screen sums from wrapping back into view before the clip test.
  assign px       = {1'b0, base_x} + XE_W'(cx);
  assign py       = {1'b0, base_y} + YE_W'(cy);
  assign sweeping = (state == ST_DRAW) || (state == ST_ERASE);
  assign last_px  = (cx == CX_LAST) && (cy == CY_LAST);

  assign vga_x      = sweeping ? px[X_W-1:0] : '0;
  assign vga_y      = sweeping ? py[Y_W-1:0] : '0;
  assign vga_colour = !sweeping ? '0 : (state == ST_ERASE) ? BG_COLOUR : col_lat;
  assign vga_plot   = sweeping && (px < CLIP_X) && (py < CLIP_Y);
  assign grant      = sweeping ? gnt_lat : '0;
  assign done       = (state == ST_DONE) ? gnt_lat : '0;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      win_idx <= '0;
      gnt_lat <= '0;
      x_lat   <= '0;
      y_lat   <= '0;
      col_lat <= '0;
      cx      <= '0;
      cy      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            win_idx <= arb_idx;
            gnt_lat <= arb_winner;
            x_lat   <= x_in[arb_idx*X_W +: X_W];
            y_lat   <= y_in[arb_idx*Y_W +: Y_W];
            col_lat <= colour_in[arb_idx*COLOUR_W +: COLOUR_W];
            cx      <= '0;
            cy      <= '0;
            state   <= idle_next;
          end
        end
        ST_ERASE, ST_DRAW: begin
          if (last_px) begin
            cx    <= '0;
            cy    <= '0;
            state <= (state == ST_ERASE) ? ST_DRAW : ST_DONE;
          end else if (cx == CX_LAST) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler with a pixel scoreboard fed at stimulus time.
module tb_sprite_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] x_in = '0;
  logic [27:0] y_in = '0;
  logic [11:0] colour_in = '0;
  logic [3:0]  grant, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_plot  = 0;
  int n_grant = 0;
  logic [17:0] exp_q [$];

  sprite_draw_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .grant(grant), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Row-major reference sweep with clipping, independent of the RTL counters.
  task automatic push_block(input int x, input int y, input int c);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        if (x + xx < 160 && y + yy < 120)
          exp_q.push_back({8'(x + xx), 7'(y + yy), 3'(c)});
  endtask

  task automatic set_src(input int i, input int x, input int y, input int c);
    x_in[i*8 +: 8]      = 8'(x);
    y_in[i*7 +: 7]      = 7'(y);
    colour_in[i*3 +: 3] = 3'(c);
  endtask

  task automatic wait_done(input int idx, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clock);
      n++;
      if (done[idx]) break;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (grant != 4'b0) n_grant++;
    if (vga_plot === 1'b1) begin
      n_plot++;
      if (exp_q.size() == 0) chk("plot_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, prev, last, nrise, cyc;
    int order [5] = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clock); #1 reset = 1'b0;

    // Single request
    @(posedge clock); #1;
    n_plot = 0; n_grant = 0;
    set_src(0, 10, 20, 4);
    push_block(10, 20, 4);
    req = 4'b0001;
    wait_done(0, 40, n);
    chk("single_latency", 32'(n), 32'd18);
    chk("single_grant_in_done", 32'(grant), 0);
    chk("single_plot_in_done", 32'(vga_plot), 0);
    req = 4'b0000;
    @(negedge clock);
    chk("single_done_width", 32'(done), 0);
    chk("single_busy_after", 32'(busy), 0);
    chk("single_grant_cycles", 32'(n_grant), 32'd16);
    chk("single_plots", 32'(n_plot), 32'd16);
    chk("single_q_empty", 32'(exp_q.size()), 0);

    // All four requesting continuously from reset
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 20 + 10 * i, 30 + 5 * i, i + 1);
    for (int k = 0; k < 5; k++) push_block(20 + 10 * order[k], 30 + 5 * order[k], order[k] + 1);
    req = 4'b1111;
    do_reset();
    prev = 0; last = 0; nrise = 0; cyc = 0;
    while (cyc < 150 && nrise < 5) begin
      @(negedge clock);
      cyc++;
      if (grant != 4'b0 && prev == 0) begin
        chk("rr_order", 32'(grant), 32'(4'b0001 << order[nrise]));
        if (nrise > 0) chk("rr_gap", 32'(cyc - last), 32'd18);
        last = cyc;
        nrise++;
      end
      prev = int'(grant);
    end
    chk("rr_rises", 32'(nrise), 32'd5);
    req = 4'b0000;
    wait_done(0, 30, n);
    chk("rr_final_done", 32'(n < 30), 32'd1);
    chk("rr_q_empty", 32'(exp_q.size()), 0);

    // Right/bottom clipping on requester 1
    @(posedge clock); #1;
    n_plot = 0; n_grant = 0;
    set_src(1, 158, 118, 6);
    push_block(158, 118, 6);
    req = 4'b0010;
    wait_done(1, 40, n);
    req = 4'b0000;
    chk("clip_latency", 32'(n), 32'd18);
    chk("clip_plots", 32'(n_plot), 32'd4);
    chk("clip_grant_cycles", 32'(n_grant), 32'd16);
    chk("clip_q_empty", 32'(exp_q.size()), 0);

    // Request dropped mid-draw on requester 2
    @(posedge clock); #1;
    n_plot = 0;
    set_src(2, 50, 60, 3);
    push_block(50, 60, 3);
    req = 4'b0100;
    repeat (6) @(negedge clock);
    req = 4'b0000;
    set_src(2, 5, 5, 7);
    wait_done(2, 30, n);
    chk("drop_remaining", 32'(n), 32'd12);
    chk("drop_plots", 32'(n_plot), 32'd16);

    // Reset mid-draw on requester 3, then arbitration restarts at 0
    @(posedge clock); #1;
    set_src(3, 70, 80, 2);
    for (int p = 0; p < 8; p++) exp_q.push_back({8'(70 + p % 4), 7'(80 + p / 4), 3'd2});
    req = 4'b1000;
    repeat (9) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midrst_plot", 32'(vga_plot), 0);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_q_empty", 32'(exp_q.size()), 0);
    set_src(0, 90, 100, 1);
    push_block(90, 100, 1);
    req = 4'b1001;
    reset = 1'b0;
    n = 0;
    while (n < 5 && grant == 4'b0) begin @(negedge clock); n++; end
    chk("midrst_first_grant", 32'(grant), 32'(4'b0001));
    wait_done(0, 30, n);
    req = 4'b0000;
    chk("midrst_done_seen", 32'(n < 30), 32'd1);
    chk("midrst_q_empty2", 32'(exp_q.size()), 0);

`ifdef SPRITE_DRAW_SCHEDULER_ERASE_EN
    // Erase of the previous position before redraw
    req = 4'b0000;
    do_reset();
    set_src(0, 30, 40, 5);
    push_block(30, 40, 5);
    req = 4'b0001;
    wait_done(0, 40, n);
    chk("erase_first_latency", 32'(n), 32'd18);
    set_src(0, 31, 40, 5);
    push_block(30, 40, 0);
    push_block(31, 40, 5);
    wait_done(0, 60, n);
    req = 4'b0000;
    chk("erase_second_latency", 32'(n), 32'd34);
    chk("erase_q_empty", 32'(exp_q.size()), 0);
`endif

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
